// File: rtl/adder_bist_checker.sv
// Exhaustive self-test sweep for a 2-bit adder: drives all 16 operand pairs,
// samples {co,s1,s0} after SETTLE cycles and accumulates mismatch results.
module adder_bist_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a0,
    output logic       a1,
    output logic       b0,
    output logic       b1,
    input  logic       s0,
    input  logic       s1,
    input  logic       co,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid,
    output logic       fail_pulse,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t     state;
    state_t     next_state;
    logic [3:0] vec;
    logic [3:0] wait_cnt;
    logic [2:0] expected;
    logic       mismatch;
    logic       sweep_start;
    logic       vec_inc;

    // vec doubles as the operand register: it only moves on entry to APPLY.
    assign {a1, a0, b1, b0} = vec;

    assign expected = {1'b0, vec[3:2]} + {1'b0, vec[1:0]};
    assign mismatch = ({co, s1, s0} != expected);

    assign busy      = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
    assign done      = (state == S_DONE);
    assign pass      = (state == S_DONE) && (err_count == 5'd0);
    assign state_dbg = state;

    always_comb begin
        next_state  = state;
        sweep_start = 1'b0;
        vec_inc     = 1'b0;
        fail_pulse  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state  = S_APPLY;
                    sweep_start = 1'b1;
                end
            end
            S_APPLY: begin
                if (SETTLE == 0) next_state = S_CHECK;
                else             next_state = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == SETTLE_LAST) next_state = S_CHECK;
            end
            S_CHECK: begin
                fail_pulse = mismatch;
                if (vec == 4'd15) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_APPLY;
                    vec_inc    = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            vec              <= 4'd0;
            wait_cnt         <= 4'd0;
            err_count        <= 5'd0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (sweep_start) begin
                vec              <= 4'd0;
                err_count        <= 5'd0;
                first_fail_vec   <= 4'd0;
                first_fail_valid <= 1'b0;
            end else begin
                if (vec_inc) vec <= vec + 4'd1;
                // Only the first mismatch of a sweep is latched.
                if (fail_pulse) begin
                    err_count <= err_count + 5'd1;
                    if (!first_fail_valid) begin
                        first_fail_vec   <= vec;
                        first_fail_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench for adder_bist_checker: two instances (SETTLE=0 and SETTLE=1), each
// wired to a modelled adder with a selectable fault.
module tb_adder_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] start;
  logic [1:0] a0_w, a1_w, b0_w, b1_w, s0_w, s1_w, co_w;
  logic [1:0] busy_w, done_w, pass_w, ffvalid_w, fp_w;
  logic [4:0] err_w [2];
  logic [3:0] ffv_w [2];
  logic [2:0] st_w [2];
  int         fm [2];   // 0 ideal, 1 co stuck at 0, 2 s0 inverted

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  logic [4:0]  exp_q [2][$];   // {vector, expected fail_pulse} per CHECK
  logic [10:0] res_q [2][$];   // {err_count, first_fail_vec, first_fail_valid, pass}
  int          done_q [2][$];  // cycle at which done must rise

  function automatic logic [2:0] adder_model(input logic [3:0] v, input int mode);
    logic [2:0] r;
    r = {1'b0, v[3:2]} + {1'b0, v[1:0]};
    if (mode == 1) r[2] = 1'b0;
    if (mode == 2) r[0] = ~r[0];
    return r;
  endfunction

  assign {co_w[0], s1_w[0], s0_w[0]} = adder_model({a1_w[0], a0_w[0], b1_w[0], b0_w[0]}, fm[0]);
  assign {co_w[1], s1_w[1], s0_w[1]} = adder_model({a1_w[1], a0_w[1], b1_w[1], b0_w[1]}, fm[1]);

  adder_bist_checker #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .a0(a0_w[0]), .a1(a1_w[0]), .b0(b0_w[0]), .b1(b1_w[0]),
    .s0(s0_w[0]), .s1(s1_w[0]), .co(co_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .first_fail_vec(ffv_w[0]),
    .first_fail_valid(ffvalid_w[0]), .fail_pulse(fp_w[0]), .state_dbg(st_w[0])
  );

  adder_bist_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .a0(a0_w[1]), .a1(a1_w[1]), .b0(b0_w[1]), .b1(b1_w[1]),
    .s0(s0_w[1]), .s1(s1_w[1]), .co(co_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .first_fail_vec(ffv_w[1]),
    .first_fail_valid(ffvalid_w[1]), .fail_pulse(fp_w[1]), .state_dbg(st_w[1])
  );

  // Monitor: pops expectations whenever a DUT shows CHECK or a rising done.
  logic [1:0]  prev_done = 2'b00;
  logic [4:0]  e_chk;
  logic [10:0] e_res;
  int          e_cyc;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (st_w[d] == 3'd3) begin
        n_tests++;
        if (exp_q[d].size() == 0) begin
          n_fail++;
          $display("FAIL chk_unexpected dut%0d: CHECK at vec %0d, none expected", d,
                   {a1_w[d], a0_w[d], b1_w[d], b0_w[d]});
        end else begin
          e_chk = exp_q[d].pop_front();
          if ({a1_w[d], a0_w[d], b1_w[d], b0_w[d], fp_w[d]} !== e_chk) begin
            n_fail++;
            $display("FAIL chk dut%0d: got vec/fail_pulse %b, expected %b", d,
                     {a1_w[d], a0_w[d], b1_w[d], b0_w[d], fp_w[d]}, e_chk);
          end
        end
      end
      if (done_w[d] && !prev_done[d]) begin
        n_tests++;
        if (res_q[d].size() == 0 || done_q[d].size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected dut%0d: done rose at cycle %0d, none expected", d, cyc);
        end else begin
          e_res = res_q[d].pop_front();
          e_cyc = done_q[d].pop_front();
          if ({err_w[d], ffv_w[d], ffvalid_w[d], pass_w[d]} !== e_res || cyc != e_cyc) begin
            n_fail++;
            $display("FAIL result dut%0d: got err/ffv/ffvalid/pass %b at cycle %0d, expected %b at cycle %0d",
                     d, {err_w[d], ffv_w[d], ffvalid_w[d], pass_w[d]}, cyc, e_res, e_cyc);
          end
        end
      end
      prev_done[d] = done_w[d];
    end
  end

  task automatic push_sweep(input int d, input logic [15:0] mask, input int n_vec,
                            input logic [10:0] res, input int done_cyc);
    for (int v = 0; v < n_vec; v++) exp_q[d].push_back({4'(v), mask[v]});
    if (n_vec == 16) begin
      res_q[d].push_back(res);
      done_q[d].push_back(done_cyc);
    end
  endtask

  task automatic run_sweep(input int d, input int settle, input logic [15:0] mask,
                           input int n_vec, input logic [10:0] res, output int c0);
    @(negedge clk);
    c0 = cyc + 1;
    push_sweep(d, mask, n_vec, res, c0 + 16 * (settle + 2));
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_reset(input int d, input string name);
    logic [19:0] act;
    act = {a1_w[d], a0_w[d], b1_w[d], b0_w[d], busy_w[d], done_w[d], pass_w[d],
           err_w[d], ffv_w[d], ffvalid_w[d], fp_w[d]};
    n_tests++;
    if (act !== 20'd0) begin
      n_fail++;
      $display("FAIL %s dut%0d: outputs %b, expected all zero", name, d, act);
    end
  endtask

  task automatic check_queues_empty(input int d);
    n_tests++;
    if (exp_q[d].size() != 0 || res_q[d].size() != 0 || done_q[d].size() != 0) begin
      n_fail++;
      $display("FAIL queues_empty dut%0d: %0d/%0d/%0d pending, expected 0/0/0", d,
               exp_q[d].size(), res_q[d].size(), done_q[d].size());
    end
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    start = 2'b00;
    fm[0] = 0;
    fm[1] = 0;
    repeat (3) @(negedge clk);
    check_reset(0, "reset_init");
    check_reset(1, "reset_init");
    rst_n = 1'b1;

    // Ideal adder, SETTLE=1: done 48 cycles after start edge, pass.
    fm[1] = 0;
    run_sweep(1, 1, 16'h0000, 16, {5'd0, 4'd0, 1'b0, 1'b1}, c0);
    wait_until(c0 + 50);

    // co stuck at 0: fails on vectors 7,10,11,13,14,15.
    fm[1] = 1;
    run_sweep(1, 1, 16'hEC80, 16, {5'd6, 4'd7, 1'b1, 1'b0}, c0);
    wait_until(c0 + 50);

    // s0 inverted: every vector fails, first at 0.
    fm[1] = 2;
    run_sweep(1, 1, 16'hFFFF, 16, {5'd16, 4'd0, 1'b1, 1'b0}, c0);
    wait_until(c0 + 50);

    // SETTLE=0 instance, ideal: done 32 cycles after start edge.
    fm[0] = 0;
    run_sweep(0, 0, 16'h0000, 16, {5'd0, 4'd0, 1'b0, 1'b1}, c0);
    wait_until(c0 + 34);

    // Reset while vector 5 is applied; vectors 0..4 have already failed.
    fm[1] = 2;
    run_sweep(1, 1, 16'hFFFF, 5, 11'd0, c0);
    wait_until(c0 + 15);
    n_tests++;
    if (err_w[1] !== 5'd5 || {a1_w[1], a0_w[1], b1_w[1], b0_w[1]} !== 4'd5) begin
      n_fail++;
      $display("FAIL pre_reset dut1: err_count %0d vec %0d, expected 5 and 5", err_w[1],
               {a1_w[1], a0_w[1], b1_w[1], b0_w[1]});
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset(1, "reset_mid_sweep");
    fm[1] = 0;
    run_sweep(1, 1, 16'h0000, 16, {5'd0, 4'd0, 1'b0, 1'b1}, c0);
    wait_until(c0 + 50);

    // start held through a sweep, released 3 cycles after done: back-to-back sweeps.
    @(negedge clk);
    c0 = cyc + 1;
    push_sweep(1, 16'h0000, 16, {5'd0, 4'd0, 1'b0, 1'b1}, c0 + 48);
    push_sweep(1, 16'h0000, 16, {5'd0, 4'd0, 1'b0, 1'b1}, c0 + 97);
    start[1] = 1'b1;
    wait_until(c0 + 48);
    repeat (3) @(negedge clk);
    start[1] = 1'b0;
    wait_until(c0 + 99);

    check_queues_empty(0);
    check_queues_empty(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
